reg_rename_file: RTL

Architectural register file with per-register rename tags, sitting directly downstream of the reorder buffer's commit port and beside the decoder's dispatch path. It records which ROB entry will produce each register, absorbs in-order commits from the ROB, and answers the decoder's operand lookups. Each lookup returns either a ready value or the ROB tag to wait on, using the ROB's ready/value query as a forwarding source. On a branch-mispredict clear it drops all rename tags and keeps the architectural values.

---
 rtl/reg_rename_file_if.sv | 71 +++++++
 rtl/reg_rename_file.sv | 133 +++++++++++++
 2 files changed

// File: rtl/reg_rename_file_if.sv
// ============================================================================
// Module   : reg_rename_file_if
// Purpose  : Bundles the dispatch, commit and operand-lookup signals between
//            the decoder/ROB side (master) and the renaming register file
//            (slave).
// Signals  : rdy_in, clear_flag            global ready / mispredict flush
//            commit_*                      in-order ROB commit port
//            rename_*                      destination rename from dispatch
//            rs1_idx/rs2_idx               decoder source registers
//            rob_rsN_id/ready/val          ROB forwarding query
//            rsN_dep/rsN_tag/rsN_val       lookup results
// Macros   : ROB_WIDTH_BIT (default 4) sets the ROB id width.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

interface reg_rename_file_if #(
  parameter int ROB_WIDTH_BIT = `ROB_WIDTH_BIT
);
  logic                     rdy_in;
  logic                     clear_flag;
  logic                     commit_valid;
  logic [4:0]               commit_reg_id;
  logic [31:0]              commit_val;
  logic [ROB_WIDTH_BIT-1:0] commit_rob_id;
  logic [4:0]               rename_reg_id;
  logic [ROB_WIDTH_BIT-1:0] rename_rob_id;
  logic [4:0]               rs1_idx;
  logic [4:0]               rs2_idx;
  logic [ROB_WIDTH_BIT-1:0] rob_rs1_id;
  logic [ROB_WIDTH_BIT-1:0] rob_rs2_id;
  logic                     rob_rs1_ready;
  logic                     rob_rs2_ready;
  logic [31:0]              rob_rs1_val;
  logic [31:0]              rob_rs2_val;
  logic                     rs1_dep;
  logic                     rs2_dep;
  logic [ROB_WIDTH_BIT-1:0] rs1_tag;
  logic [ROB_WIDTH_BIT-1:0] rs2_tag;
  logic [31:0]              rs1_val;
  logic [31:0]              rs2_val;

  // Decoder / ROB side
  modport master (
    output rdy_in, clear_flag,
    output commit_valid, commit_reg_id, commit_val, commit_rob_id,
    output rename_reg_id, rename_rob_id,
    output rs1_idx, rs2_idx,
    output rob_rs1_ready, rob_rs2_ready, rob_rs1_val, rob_rs2_val,
    input  rob_rs1_id, rob_rs2_id,
    input  rs1_dep, rs2_dep, rs1_tag, rs2_tag, rs1_val, rs2_val
  );

  // Register file side
  modport slave (
    input  rdy_in, clear_flag,
    input  commit_valid, commit_reg_id, commit_val, commit_rob_id,
    input  rename_reg_id, rename_rob_id,
    input  rs1_idx, rs2_idx,
    input  rob_rs1_ready, rob_rs2_ready, rob_rs1_val, rob_rs2_val,
    output rob_rs1_id, rob_rs2_id,
    output rs1_dep, rs2_dep, rs1_tag, rs2_tag, rs1_val, rs2_val
  );
endinterface

`default_nettype wire

// File: rtl/reg_rename_file.sv
// ============================================================================
// Module   : reg_rename_file
// Purpose  : Architectural register file with per-register rename tags.
//            Absorbs in-order ROB commits, records the producing ROB entry of
//            each renamed register, drops all tags on a mispredict clear and
//            answers two combinational operand lookups (value or tag to wait
//            on), using the ROB's ready/value query as a forwarding source.
// Ports    : clk_in  - system clock
//            rst_in  - synchronous active-high reset
//            bus     - reg_rename_file_if.slave (commit, rename, lookups)
// Macros   : ROB_WIDTH_BIT        default ROB id width (4)
//            RF_COMMIT_BYPASS_EN  when defined, a register committing this
//                                 cycle is returned ready with commit_val
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

module reg_rename_file #(
  parameter int ROB_WIDTH_BIT = `ROB_WIDTH_BIT
) (
  input  wire logic          clk_in,
  input  wire logic          rst_in,
  reg_rename_file_if.slave   bus
);

  typedef struct packed {
    logic                     dep;
    logic [ROB_WIDTH_BIT-1:0] tag;
    logic [31:0]              val;
  } lookup_t;

  logic [31:0]              value_q [32];
  logic [ROB_WIDTH_BIT-1:0] tag_q   [32];
  logic [31:0]              busy_q;

  lookup_t rs1_res;
  lookup_t rs2_res;

  // --------------------------------------------------------------------------
  // State update. Register x0 is never written or renamed, so it stays at
  // its reset contents (value 0, not busy, tag 0) forever.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (bus.rdy_in) begin
      if (bus.clear_flag) begin
        // The ROB head is wrong-path during its own clear cycle, so commit
        // and rename are ignored; tags survive but are no longer meaningful.
        busy_q <= '0;
      end else begin
        if (bus.commit_valid && (bus.commit_reg_id != 5'd0)) begin
          value_q[bus.commit_reg_id] <= bus.commit_val;
          // Release only when the committing entry is the latest producer;
          // a stale commit leaves the newer rename in flight.
          if (busy_q[bus.commit_reg_id] &&
              (tag_q[bus.commit_reg_id] == bus.commit_rob_id)) begin
            busy_q[bus.commit_reg_id] <= 1'b0;
          end
        end
        // Placed after the commit release so a same-register rename wins.
        if (bus.rename_reg_id != 5'd0) begin
          busy_q[bus.rename_reg_id] <= 1'b1;
          tag_q[bus.rename_reg_id]  <= bus.rename_rob_id;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Operand lookup against pre-rename state, so an instruction whose rd
  // equals one of its rs sees the older producer.
  // --------------------------------------------------------------------------
  function automatic lookup_t lookup(
    input logic [4:0]  idx,
    input logic        rob_ready,
    input logic [31:0] rob_val,
    input logic        cm_valid,
    input logic [4:0]  cm_reg,
    input logic [ROB_WIDTH_BIT-1:0] cm_rob,
    input logic [31:0] cm_val
  );
    lookup_t res;
    res = '0;
    if ((idx == 5'd0) || !busy_q[idx]) begin
      res.val = value_q[idx];
`ifdef RF_COMMIT_BYPASS_EN
    end else if (cm_valid && (cm_rob == tag_q[idx]) && (cm_reg == idx)) begin
      res.val = cm_val;
`endif
    end else if (rob_ready) begin
      res.val = rob_val;
    end else begin
      res.dep = 1'b1;
      res.tag = tag_q[idx];
    end
`ifndef RF_COMMIT_BYPASS_EN
    // Commit inputs only feed the bypass path.
    res.val = res.val | ({32{1'b0 & cm_valid & (^cm_reg) & (^cm_rob)}} & cm_val);
`endif
    return res;
  endfunction

  always_comb begin
    rs1_res = lookup(bus.rs1_idx, bus.rob_rs1_ready, bus.rob_rs1_val,
                     bus.commit_valid, bus.commit_reg_id, bus.commit_rob_id,
                     bus.commit_val);
    rs2_res = lookup(bus.rs2_idx, bus.rob_rs2_ready, bus.rob_rs2_val,
                     bus.commit_valid, bus.commit_reg_id, bus.commit_rob_id,
                     bus.commit_val);
  end

  assign bus.rob_rs1_id = tag_q[bus.rs1_idx];
  assign bus.rob_rs2_id = tag_q[bus.rs2_idx];
  assign bus.rs1_dep    = rs1_res.dep;
  assign bus.rs1_tag    = rs1_res.tag;
  assign bus.rs1_val    = rs1_res.val;
  assign bus.rs2_dep    = rs2_res.dep;
  assign bus.rs2_tag    = rs2_res.tag;
  assign bus.rs2_val    = rs2_res.val;

endmodule

`default_nettype wire
